// File: rtl/morse_sequencer.sv
// morse_sequencer: queues 3-bit letter codes (S..Z) in a small FIFO and shifts each
// letter's Morse pattern onto morse_out at the tick rate, with a fixed low gap after
// every letter. Optional feature macro: MORSE_REPEAT_EN (adds repeat_en input that
// resends the last letter forever while the FIFO stays empty).
module morse_sequencer #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned GAP_TICKS  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          clear_b,
  input  logic [2:0]                    letter_in,
  input  logic                          letter_valid,
  output logic                          letter_ready,
  input  logic                          abort,
`ifdef MORSE_REPEAT_EN
  input  logic                          repeat_en,
`endif
  output logic                          morse_out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam int unsigned GapW = $clog2(GAP_TICKS + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [DivW-1:0] DivMax   = DivW'(TICK_DIV - 1);
  localparam logic [GapW-1:0] GapLoad  = GapW'(GAP_TICKS);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [12:0]     shreg_q, shreg_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic            morse_q, morse_d;
  logic            done_q, done_d;
  logic [2:0]      last_q, last_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2:0]      mem_q [FIFO_DEPTH];

  logic        push, pop, load, tick, fifo_empty, rep;
  logic [2:0]  load_code;
  logic [16:0] cb;

  // Pattern left-justified in 13 bits, length in the top nibble.
  function automatic logic [16:0] codebook(input logic [2:0] code);
    logic [16:0] r;
    case (code)
      3'd0:    r = {4'd5,  13'b1010100000000};
      3'd1:    r = {4'd3,  13'b1110000000000};
      3'd2:    r = {4'd7,  13'b1010111000000};
      3'd3:    r = {4'd9,  13'b1010101110000};
      3'd4:    r = {4'd9,  13'b1011101110000};
      3'd5:    r = {4'd11, 13'b1110101011100};
      3'd6:    r = {4'd13, 13'b1110101110111};
      default: r = {4'd11, 13'b1110111010100};
    endcase
    return r;
  endfunction

`ifdef MORSE_REPEAT_EN
  assign rep = repeat_en;
`else
  assign rep = 1'b0;
`endif

  assign fifo_empty   = (count_q == '0);
  assign tick         = (div_q == '0);
  // With an empty FIFO the only possible load is a repeat of the last letter.
  assign load_code    = fifo_empty ? last_q : mem_q[rd_ptr_q];
  assign cb           = codebook(load_code);

  assign letter_ready = (count_q != CntFull);
  assign morse_out    = morse_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign fifo_count   = count_q;

  // Next-state logic for the transmit FSM, shifter and counters.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    div_d     = div_q;
    morse_d   = morse_q;
    done_d    = 1'b0;
    last_d    = last_q;
    load      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
        end
      end
      StShift: begin
        div_d = tick ? DivMax : div_q - DivW'(1);
        if (tick) begin
          if (bit_cnt_q == 4'd1) begin
            morse_d   = 1'b0;
            gap_cnt_d = GapLoad;
            state_d   = StGap;
          end else begin
            morse_d   = shreg_q[12];
            shreg_d   = {shreg_q[11:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
      end
      StGap: begin
        div_d = tick ? DivMax : div_q - DivW'(1);
        if (tick) begin
          if (gap_cnt_q == GapW'(1)) begin
            if (!fifo_empty || rep) begin
              pop  = !fifo_empty;
              load = 1'b1;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GapW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d   = StShift;
      morse_d   = cb[12];
      shreg_d   = {cb[11:0], 1'b0};
      bit_cnt_d = cb[16:13];
      div_d     = DivMax;
      last_d    = load_code;
    end

    if (abort) begin
      state_d = StIdle;
      morse_d = 1'b0;
      done_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  // FIFO pointer/occupancy update; abort flushes and drops a same-cycle push.
  always_comb begin
    push     = letter_valid && letter_ready && !abort;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      div_q     <= '0;
      morse_q   <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      div_q     <= div_d;
      morse_q   <= morse_d;
      done_q    <= done_d;
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (clear_b && push) begin
      mem_q[wr_ptr_q] <= letter_in;
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: a queue-based model expands each letter into its per-cycle
// line waveform and is compared against the DUT every cycle; directed tests add literal
// expectations for reset, single T, Z pattern, FIFO full and abort.
module tb_morse_sequencer;

  localparam int TickDiv = 4;
  localparam int GapTicks = 3;
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       clear_b = 1'b0;
  logic [2:0] letter_in = 3'd0;
  logic       letter_valid = 1'b0;
  logic       letter_ready;
  logic       abort = 1'b0;
  logic       morse_out;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  morse_sequencer #(
    .TICK_DIV  (TickDiv),
    .GAP_TICKS (GapTicks),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk         (clk),
    .clear_b     (clear_b),
    .letter_in   (letter_in),
    .letter_valid(letter_valid),
    .letter_ready(letter_ready),
    .abort       (abort),
`ifdef MORSE_REPEAT_EN
    .repeat_en   (1'b0),
`endif
    .morse_out   (morse_out),
    .busy        (busy),
    .done        (done),
    .fifo_count  (fifo_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  string pats[8] = '{"10101", "111", "1010111", "101010111", "101110111",
                     "11101010111", "1110101110111", "11101110101"};

  // Model state: pending letters and the remaining per-cycle line waveform.
  int q_fifo[$];
  bit line[$];
  bit m_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expand(input int code);
    string p = pats[code];
    for (int i = 0; i < p.len(); i++)
      for (int k = 0; k < TickDiv; k++) line.push_back(p[i] == "1");
    for (int k = 0; k < GapTicks * TickDiv; k++) line.push_back(1'b0);
  endtask

  // Model: one step per rising edge, from the same inputs the DUT sees.
  initial forever begin
    bit take;
    bit ended;
    int cap;
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (!clear_b || abort) begin
      q_fifo.delete();
      line.delete();
    end else begin
      take  = letter_valid && (q_fifo.size() < Depth);
      cap   = int'(letter_in);
      ended = 1'b0;
      if (line.size() > 0) begin
        void'(line.pop_front());
        ended = (line.size() == 0);
      end
      if (line.size() == 0 && q_fifo.size() > 0) expand(q_fifo.pop_front());
      else if (ended) m_done = 1'b1;
      if (take) q_fifo.push_back(cap);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("m_morse_out", int'(morse_out), (line.size() > 0) ? int'(line[0]) : 0);
      chk("m_busy", int'(busy), int'(line.size() > 0));
      chk("m_done", int'(done), int'(m_done));
      chk("m_fifo_count", int'(fifo_count), q_fifo.size());
      chk("m_letter_ready", int'(letter_ready), int'(q_fifo.size() < Depth));
    end
  end

  // Offer a code and hold valid until accepted; returns at the negedge after acceptance.
  task automatic push(input logic [2:0] code, output int n_edge);
    int  n = 0;
    bit  acc = 1'b0;
    letter_in    = code;
    letter_valid = 1'b1;
    while (!acc && n < 2000) begin
      acc = letter_ready;
      @(negedge clk);
      n++;
    end
    letter_valid = 1'b0;
    n_edge = cyc;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  int zexp[14] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
  int codes[6] = '{0, 2, 3, 4, 5, 6};

  initial begin
    int n;
    int t0;
    repeat (2) @(negedge clk);
    clear_b = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(letter_ready), 1);
    chk("rst_count", int'(fifo_count), 0);

    // Single T: line high N+1..N+12, low until done at N+25.
    push(3'd1, n);
    goto(n + 1);
    chk("t_first_bit", int'(morse_out), 1);
    chk("t_busy_rise", int'(busy), 1);
    goto(n + 12);
    chk("t_last_high", int'(morse_out), 1);
    goto(n + 13);
    chk("t_gap_low", int'(morse_out), 0);
    goto(n + 24);
    chk("t_no_early_done", int'(done), 0);
    chk("t_busy_in_gap", int'(busy), 1);
    goto(n + 25);
    chk("t_done", int'(done), 1);
    chk("t_busy_fall", int'(busy), 0);
    goto(n + 26);
    chk("t_done_pulse", int'(done), 0);
    repeat (3) @(negedge clk);

    // Z pattern sampled mid-tick.
    push(3'd7, n);
    for (int k = 0; k < 14; k++) begin
      goto(n + 3 + TickDiv * k);
      chk($sformatf("z_tick%0d", k), int'(morse_out), zexp[k]);
    end
    wait_done();
    repeat (3) @(negedge clk);

    // FIFO full with six letters held back-to-back.
    for (int i = 0; i < 5; i++) push(codes[i][2:0], n);
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(letter_ready), 0);
    t0 = cyc;
    push(codes[5][2:0], n);
    chk("sixth_waited", int'(n - t0 > 10), 1);
    wait_done();
    repeat (3) @(negedge clk);

    // Abort mid-U with two letters queued; a same-cycle push is dropped.
    push(3'd2, n);
    push(3'd0, t0);
    push(3'd1, t0);
    goto(n + 10);
    chk("ab_pre_count", int'(fifo_count), 2);
    abort        = 1'b1;
    letter_in    = 3'd6;
    letter_valid = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    letter_valid = 1'b0;
    chk("ab_morse", int'(morse_out), 0);
    chk("ab_count", int'(fifo_count), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    repeat (30) @(negedge clk);
    push(3'd1, n);
    goto(n + 1);
    chk("ab_restart", int'(morse_out), 1);
    wait_done();
    repeat (3) @(negedge clk);

    // Reset mid-letter.
    push(3'd5, n);
    push(3'd3, t0);
    goto(n + 8);
    clear_b = 1'b0;
    @(negedge clk);
    chk("mr_morse", int'(morse_out), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    chk("mr_count", int'(fifo_count), 0);
    chk("mr_ready", int'(letter_ready), 1);
    @(negedge clk);
    clear_b = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle %0d: got timeout expected completion", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Transmit scheduler for the Morse letter datapath (S–Z codebook, serial shift-out, tick-rate divider). It accepts 3-bit letter codes through a valid/ready handshake into a small FIFO. It drains the FIFO one letter at a time, shifting each pattern onto a single output line at the tick rate. A fixed low gap separates consecutive letters, and the block reports busy/done status.

## Interface
- `TICK_DIV`, default 25000000: clock cycles per Morse tick (0.5 s at 50 MHz); minimum 2.
- `GAP_TICKS`, default 3: low ticks inserted after every letter; minimum 1.
- `FIFO_DEPTH`, default 4: letter FIFO entries; power of two.
- `clk` input 1: system clock (CLOCK_50 at top level).
- `clear_b` input 1: reset, synchronous, active-low.
- `letter_in` input 3: letter code, 0=S 1=T 2=U 3=V 4=W 5=X 6=Y 7=Z.
- `letter_valid` input 1: `letter_in` is offered.
- `letter_ready` output 1: FIFO not full; a push occurs when valid&&ready at a rising edge.
- `abort` input 1: synchronous flush and stop.
- `morse_out` output 1: registered serial Morse line, drives LEDR[0].
- `busy` output 1: high in SHIFT or GAP.
- `done` output 1: one-cycle pulse when the line returns to idle after the last letter.
- `fifo_count` output clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Codebook: pattern bits are sent left to right. The length L is given in brackets for each letter.
  - S 10101 [5]
  - T 111 [3]
  - U 1010111 [7]
  - V 101010111 [9]
  - W 101110111 [9]
  - X 11101010111 [11]
  - Y 1110101110111 [13]
  - Z 11101110101 [11]
- Internal state: a 13-bit shift register loaded left-justified, a 4-bit bit counter, a gap counter, and a tick divider counting TICK_DIV-1 down to 0.
- FSM states:
  - IDLE → SHIFT when the FIFO is non-empty. On that edge: pop the FIFO, load the pattern, set morse_out to the first bit, load the bit counter with L, set the divider to TICK_DIV-1.
  - SHIFT: on a divider wrap, shift the next bit onto morse_out and decrement the bit counter. After the L-th bit wraps: morse_out=0, load the gap counter with GAP_TICKS, go to GAP.
  - GAP: morse_out=0. At the final gap wrap:
    - If the FIFO is non-empty: pop it and load directly into SHIFT, with no idle cycle.
    - Otherwise go to IDLE and pulse `done`.
- Output hold time: every pattern bit holds for exactly TICK_DIV cycles; the gap lasts exactly GAP_TICKS*TICK_DIV cycles.
- FIFO rules:
  - Push and pop in the same cycle is legal; count is unchanged.
  - A push while full is impossible, because ready=0; valid is simply held by the source.
  - Pointers wrap modulo FIFO_DEPTH.
- `abort`: at the next edge, empty the FIFO, go to IDLE, set morse_out=0 and busy=0. No done pulse. A push offered in the same cycle is discarded. clear_b has priority over abort.
- Reset: when clear_b is low at an edge, all outputs clear: morse_out=0, busy=0, done=0, fifo_count=0, letter_ready=1. The FSM goes to IDLE and the divider clears. Reset mid-letter truncates the letter immediately.

## Timing
- Push-to-line latency from IDLE with an empty FIFO: a push accepted at edge N makes morse_out take the first bit at edge N+1.
- Letter period back-to-back: (L+GAP_TICKS)*TICK_DIV cycles.
- letter_ready falls the cycle after the push that fills the FIFO, and rises the cycle after the next pop.
- busy: rises on the same edge as the first bit and falls on the same edge as `done`.
- done: high for exactly one cycle.

## Configuration
- `MORSE_REPEAT_EN` defined:
  - Adds input `repeat_en` (1 bit).
  - At the final gap wrap with an empty FIFO and repeat_en=1, the last letter is reloaded and resent. No done pulse is issued and busy stays high.
  - abort still stops transmission.
- `MORSE_REPEAT_EN` undefined: no `repeat_en` port; behaviour is identical to repeat_en=0.

## Test plan
- Reset: hold clear_b=0 for 2 cycles mid-letter → morse_out=0, busy=0, done=0, fifo_count=0, letter_ready=1 after the first low edge.
- Single T (TICK_DIV=4, GAP_TICKS=3): push code 1 at edge N → morse_out=1 for cycles N+1..N+12, then 0 for 12 cycles; done=1 at edge N+25 only; busy falls at the same edge.
- Pattern Z: push code 7 → the sampled line per tick reads 1,1,1,0,1,1,1,0,1,0,1, then 3 zero ticks.
- FIFO full: hold letter_valid=1 from IDLE with 6 distinct codes → first popped at once, next four fill the FIFO, fifo_count=4, letter_ready=0. The sixth is accepted only after the second letter pops. All six letters come out in push order with 3-tick gaps.
- Abort: assert abort for 1 cycle mid-U with 2 letters queued → next edge morse_out=0, fifo_count=0, busy=0, no done. A new push after that restarts normally.
- Repeat (MORSE_REPEAT_EN, repeat_en=1): push S once → S plus gap repeats indefinitely with no done. Dropping repeat_en before a gap end → done after that gap.
